// File: rtl/rw_mem_arbiter.sv
// Two-client round-robin arbiter/sequencer for a shared synchronous read/write memory.
// Define RW_ARB_FIXED_PRIO_EN to replace round-robin with fixed priority (client 0 wins ties).
module rw_mem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              Clock,
  input  logic              Reset_N,
  input  logic              Req0,
  input  logic              WE0,
  input  logic [ADDR_W-1:0] Addr0,
  input  logic [DATA_W-1:0] WData0,
  output logic              Ack0,
  input  logic              Req1,
  input  logic              WE1,
  input  logic [ADDR_W-1:0] Addr1,
  input  logic [DATA_W-1:0] WData1,
  output logic              Ack1,
  output logic [DATA_W-1:0] RData,
  output logic              Busy,
  output logic [ADDR_W-1:0] Mem_Address,
  output logic [DATA_W-1:0] Mem_Data_In,
  output logic              Mem_WE,
  input  logic [DATA_W-1:0] Mem_Data_Out
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t state;
  logic   grant;
  logic   pick;

`ifdef RW_ARB_FIXED_PRIO_EN
  always_comb begin
    pick = 1'b0;
    if (!Req0 && Req1) pick = 1'b1;
  end
`else
  logic last;

  // On a tie the client that did not win last time is served.
  always_comb begin
    pick = 1'b0;
    if (Req0 && Req1) pick = ~last;
    else if (Req1)    pick = 1'b1;
  end
`endif

  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      state       <= IDLE;
      grant       <= 1'b0;
      Mem_WE      <= 1'b0;
      Mem_Address <= '0;
      Mem_Data_In <= '0;
`ifndef RW_ARB_FIXED_PRIO_EN
      last        <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Req0 || Req1) begin
            grant       <= pick;
            Mem_WE      <= pick ? WE1    : WE0;
            Mem_Address <= pick ? Addr1  : Addr0;
            Mem_Data_In <= pick ? WData1 : WData0;
`ifndef RW_ARB_FIXED_PRIO_EN
            last        <= pick;
`endif
            state       <= ACCESS;
          end
        end
        // Memory performs the latched op on the edge that ends ACCESS.
        ACCESS: begin
          Mem_WE <= 1'b0;
          state  <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign Ack0  = (state == DONE) && !grant;
  assign Ack1  = (state == DONE) &&  grant;
  assign Busy  = (state != IDLE);
  assign RData = (state == DONE) ? Mem_Data_Out : '0;

endmodule

// File: tb/tb_rw_mem_arbiter.sv
// Randomized bench for rw_mem_arbiter with a transaction-level arbitration/memory model.
module tb_rw_mem_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              early;
  } txn_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_v  [2];
  logic              we_v   [2];
  logic [ADDR_W-1:0] addr_v [2];
  logic [DATA_W-1:0] wd_v   [2];
  logic              ack0, ack1, busy, mem_we;
  logic [DATA_W-1:0] rdata, mem_din, mem_dout;
  logic [ADDR_W-1:0] mem_addr;

  logic [DATA_W-1:0] mem [16];
  logic              mem_loaded;

  always #5 clk = ~clk;

  rw_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .Clock(clk), .Reset_N(rst_n),
    .Req0(req_v[0]), .WE0(we_v[0]), .Addr0(addr_v[0]), .WData0(wd_v[0]), .Ack0(ack0),
    .Req1(req_v[1]), .WE1(we_v[1]), .Addr1(addr_v[1]), .WData1(wd_v[1]), .Ack1(ack1),
    .RData(rdata), .Busy(busy),
    .Mem_Address(mem_addr), .Mem_Data_In(mem_din), .Mem_WE(mem_we), .Mem_Data_Out(mem_dout)
  );

  function automatic logic [DATA_W-1:0] init_val(input int i);
    return 8'(i * 37 + 5);
  endfunction

  // External 16x8 memory: write on WE, otherwise registered read.
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= init_val(i);
    end else if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end else begin
      mem_dout <= mem[mem_addr];
    end
  end

  int                n_cmp = 0;
  int                n_err = 0;
  logic [DATA_W-1:0] ref_mem [16];
  txn_t              q0[$];
  txn_t              q1[$];
  int                glog[$];
  int                exp_order [4];
  int                cyc;
  int                g_cyc;
  logic              g_c;
  txn_t              g_t;
  logic [DATA_W-1:0] exp_rd;
  logic              m_last;
  logic              pend [2];
  logic              gap_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic txn_t mk(input logic w, input logic [ADDR_W-1:0] a,
                              input logic [DATA_W-1:0] d, input logic e);
    txn_t t;
    t.we = w; t.addr = a; t.data = d; t.early = e;
    return t;
  endfunction

  function automatic int qsize(input int c);
    return (c == 0) ? q0.size() : q1.size();
  endfunction

  function automatic txn_t qhead(input int c);
    return (c == 0) ? q0[0] : q1[0];
  endfunction

  task automatic qpop(input int c);
    if (c == 0) void'(q0.pop_front());
    else        void'(q1.pop_front());
  endtask

  // Expected outputs for the cycle following posedge number cyc.
  task automatic check_cycle();
    logic in_acc, in_done;
    in_acc  = (cyc == g_cyc);
    in_done = (cyc == g_cyc + 1);
    chk("ack0", ack0, in_done && !g_c);
    chk("ack1", ack1, in_done &&  g_c);
    chk("busy", busy, in_acc || in_done);
    chk("mem_we", mem_we, in_acc && g_t.we);
    if (in_acc || in_done) chk("mem_addr", mem_addr, g_t.addr);
    if (in_acc && g_t.we)  chk("mem_din", mem_din, g_t.data);
    if (in_done && !g_t.we) chk("rdata", rdata, exp_rd);
  endtask

  task automatic update_clients();
    txn_t t;
    for (int c = 0; c < 2; c++) begin
      if (cyc == g_cyc + 1 && g_c == c[0]) begin
        qpop(c);
        pend[c] = 1'b0;
      end
      if (cyc == g_cyc && g_c == c[0]) begin
        we_v[c]   = 1'($urandom);
        addr_v[c] = 4'($urandom);
        wd_v[c]   = 8'($urandom);
        if (g_t.early) req_v[c] = 1'b0;
      end
      if (!pend[c]) begin
        if (qsize(c) > 0 && (!gap_en || $urandom_range(0, 1) == 1)) begin
          t         = qhead(c);
          req_v[c]  = 1'b1;
          we_v[c]   = t.we;
          addr_v[c] = t.addr;
          wd_v[c]   = t.data;
          pend[c]   = 1'b1;
        end else begin
          req_v[c] = 1'b0;
        end
      end
    end
  endtask

  // Arbitration decision for the next edge, taken only when the arbiter is idle.
  task automatic decide();
    int win;
    if (cyc == g_cyc || cyc == g_cyc + 1) return;
    if (!req_v[0] && !req_v[1]) return;
    if (req_v[0] && req_v[1]) begin
`ifdef RW_ARB_FIXED_PRIO_EN
      win = 0;
`else
      win = m_last ? 0 : 1;
`endif
    end else begin
      win = req_v[0] ? 0 : 1;
    end
    m_last = win[0];
    g_c    = win[0];
    g_cyc  = cyc + 1;
    g_t    = qhead(win);
    if (g_t.we) ref_mem[g_t.addr] = g_t.data;
    else        exp_rd = ref_mem[g_t.addr];
    glog.push_back(win);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    check_cycle();
    update_clients();
    decide();
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    update_clients();
    decide();
    while ((q0.size() > 0 || q1.size() > 0 || cyc <= g_cyc + 1) && n < budget) begin
      step();
      n++;
    end
    chk("run_done", n < budget, 1'b1);
    step();
    step();
  endtask

  task automatic model_reset();
    m_last  = 1'b1;
    g_cyc   = -10;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    mem_loaded = 1'b0;
    gap_en     = 1'b0;
    cyc        = 0;
    g_c        = 1'b0;
    g_t        = '0;
    exp_rd     = '0;
    for (int c = 0; c < 2; c++) begin
      req_v[c] = 1'b0; we_v[c] = 1'b0; addr_v[c] = '0; wd_v[c] = '0;
    end
    for (int i = 0; i < 16; i++) ref_mem[i] = init_val(i);
    model_reset();
`ifdef RW_ARB_FIXED_PRIO_EN
    exp_order = '{0, 0, 1, 1};
`else
    exp_order = '{0, 1, 0, 1};
`endif

    @(negedge clk);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ack0", ack0, 1'b0);
    chk("rst_ack1", ack1, 1'b0);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 4'h0);
    chk("rst_din", mem_din, 8'h00);
    @(negedge clk);
    mem_loaded = 1'b1;
    rst_n      = 1'b1;

    // Single write, then read back by the other client.
    q0.push_back(mk(1'b1, 4'h2, 8'hAA, 1'b0));
    run(50);
    q1.push_back(mk(1'b0, 4'h2, 8'h00, 1'b0));
    run(50);

    // Both clients contending.
    glog.delete();
    q0.push_back(mk(1'b1, 4'h1, 8'h11, 1'b0));
    q0.push_back(mk(1'b0, 4'h2, 8'h00, 1'b0));
    q1.push_back(mk(1'b0, 4'h1, 8'h00, 1'b0));
    q1.push_back(mk(1'b1, 4'h3, 8'h33, 1'b0));
    run(100);
    chk("order_len", glog.size(), 4);
    for (int i = 0; i < 4; i++) chk("order", glog[i], exp_order[i]);

    // Cross-client data exchange including the top and bottom addresses.
    q0.push_back(mk(1'b1, 4'hF, 8'h55, 1'b0)); run(50);
    q1.push_back(mk(1'b0, 4'hF, 8'h00, 1'b0)); run(50);
    q1.push_back(mk(1'b1, 4'h0, 8'h3C, 1'b0)); run(50);
    q0.push_back(mk(1'b0, 4'h0, 8'h00, 1'b0)); run(50);

    // Reset during the ACCESS cycle of a write aborts it.
    req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 4'h7; wd_v[0] = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    chk("abort_acc_we", mem_we, 1'b1);
    chk("abort_acc_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we", mem_we, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_ack0", ack0, 1'b0);
    req_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_addr", mem_addr, 4'h0);
    model_reset();
    q1.push_back(mk(1'b0, 4'h7, 8'h00, 1'b0));
    run(50);

    // Reset during DONE drops the Ack at once; afterwards client 0 wins a tie.
    req_v[0] = 1'b1; we_v[0] = 1'b0; addr_v[0] = 4'h3;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("done_ack0", ack0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("done_rst_ack0", ack0, 1'b0);
    chk("done_rst_busy", busy, 1'b0);
    req_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    glog.delete();
    q0.push_back(mk(1'b0, 4'h9, 8'h00, 1'b0));
    q1.push_back(mk(1'b0, 4'hA, 8'h00, 1'b0));
    run(50);
    chk("post_rst_tie", glog[0], 0);

    // Req dropped after the grant: the op still completes with one Ack.
    q0.push_back(mk(1'b1, 4'h5, 8'h12, 1'b1)); run(50);
    q1.push_back(mk(1'b0, 4'h5, 8'h00, 1'b0)); run(50);

    // Random traffic with idle gaps, early drops and payload churn.
    gap_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      txn_t t;
      t = mk(1'($urandom), 4'($urandom), 8'($urandom), $urandom_range(0, 4) == 0);
      if ($urandom_range(0, 1) == 1) q0.push_back(t);
      else                           q1.push_back(t);
    end
    run(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
